// File: rtl/coproc_pkg.sv
// coproc_pkg: shared constants, buffer-order encodings and the row loader
// state type for the coprocessor row-buffer path.
//   PIX_W / IMG_COLS : pixel width and row length (row-buffer width)
//   SEL_Bx_TOP       : one-hot reg_sel codes naming the buffer holding the top row
//   rowload_state_t  : row loader FSM states; the pad states exist only when
//                      ROWLOAD_ZERO_PAD_EN is defined
package coproc_pkg;

  localparam int PIX_W    = 12;
  localparam int IMG_COLS = 256;

  localparam logic [2:0] SEL_B0_TOP = 3'b100;
  localparam logic [2:0] SEL_B1_TOP = 3'b001;
  localparam logic [2:0] SEL_B2_TOP = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
`ifdef ROWLOAD_ZERO_PAD_EN
    ST_PAD_TOP  = 3'd1,
`endif
    ST_FILL     = 3'd2,
    ST_WAIT_ACK = 3'd3,
`ifdef ROWLOAD_ZERO_PAD_EN
    ST_PAD_BOT  = 3'd4,
`endif
    ST_DONE     = 3'd5
  } rowload_state_t;

  // Next buffer in the b0 -> b1 -> b2 -> b0 rotation.
  function automatic logic [1:0] next_buf(input logic [1:0] b);
    case (b)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Write strobe for a buffer index (bit i = buffer i).
  function automatic logic [2:0] buf_onehot(input logic [1:0] b);
    case (b)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // reg_sel code for a window whose top row sits in buffer b.
  function automatic logic [2:0] top_sel(input logic [1:0] b);
    case (b)
      2'd0:    return SEL_B0_TOP;
      2'd1:    return SEL_B1_TOP;
      default: return SEL_B2_TOP;
    endcase
  endfunction

endpackage

// File: rtl/row_buf_loader.sv
// row_buf_loader: write-side controller for the three row buffers.
// Takes a raster pixel stream (pix_in/pix_valid/pix_ready), writes each row
// into the next buffer in rotation (wr_en/wr_col/wr_data), and hands each
// complete 3-row window to the reader (row_ready/reg_sel/row_idx, row_ack).
// start launches a frame, busy marks a frame in progress, frame_done pulses
// at frame end. clk/rst: clock and asynchronous active-high reset.
// Build option ROWLOAD_ZERO_PAD_EN adds all-zero border rows above and below
// the image so every image row becomes a window center.
module row_buf_loader #(
  parameter int PIX_W    = coproc_pkg::PIX_W,
  parameter int IMG_COLS = coproc_pkg::IMG_COLS,
  parameter int IMG_ROWS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [2:0]       wr_en,
  output logic [7:0]       wr_col,
  output logic [PIX_W-1:0] wr_data,
  output logic [2:0]       reg_sel,
  output logic             row_ready,
  output logic [7:0]       row_idx,
  input  logic             row_ack,
  output logic             busy,
  output logic             frame_done
);
  import coproc_pkg::*;

  localparam logic [7:0] COL_LAST  = 8'(IMG_COLS - 1);
  localparam logic [8:0] LAST_ROWS = 9'(IMG_ROWS);
`ifdef ROWLOAD_ZERO_PAD_EN
  // The top pad row already occupies b0, so two image rows complete a window.
  localparam logic [8:0] MIN_ROWS  = 9'd2;
`else
  localparam logic [8:0] MIN_ROWS  = 9'd3;
`endif

  rowload_state_t   state_r;
  logic [7:0]       col_r;
  logic [8:0]       rows_r;
  logic [8:0]       rows_new_s;
  logic [1:0]       wr_buf_r;
`ifdef ROWLOAD_ZERO_PAD_EN
  logic             bot_done_r;
`endif
  logic             pix_ready_r;
  logic [2:0]       wr_en_r;
  logic [7:0]       wr_col_r;
  logic [PIX_W-1:0] wr_data_r;
  logic [2:0]       reg_sel_r;
  logic             row_ready_r;
  logic [7:0]       row_idx_r;
  logic             busy_r;
  logic             frame_done_r;

  assign rows_new_s = rows_r + 9'd1;

  // Frame sequencer: state, counters and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      col_r        <= 8'd0;
      rows_r       <= 9'd0;
      wr_buf_r     <= 2'd0;
`ifdef ROWLOAD_ZERO_PAD_EN
      bot_done_r   <= 1'b0;
`endif
      pix_ready_r  <= 1'b0;
      wr_en_r      <= 3'b000;
      wr_col_r     <= 8'd0;
      wr_data_r    <= {PIX_W{1'b0}};
      reg_sel_r    <= 3'b000;
      row_ready_r  <= 1'b0;
      row_idx_r    <= 8'd0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      // Strobes and pulses fall back to idle unless a state re-asserts them.
      wr_en_r      <= 3'b000;
      row_ready_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          col_r    <= 8'd0;
          rows_r   <= 9'd0;
          wr_buf_r <= 2'd0;
`ifdef ROWLOAD_ZERO_PAD_EN
          bot_done_r <= 1'b0;
`endif
          if (start) begin
            busy_r <= 1'b1;
`ifdef ROWLOAD_ZERO_PAD_EN
            state_r     <= ST_PAD_TOP;
            pix_ready_r <= 1'b0;
`else
            state_r     <= ST_FILL;
            pix_ready_r <= 1'b1;
`endif
          end else begin
            busy_r      <= 1'b0;
            pix_ready_r <= 1'b0;
          end
        end
`ifdef ROWLOAD_ZERO_PAD_EN
        ST_PAD_TOP: begin
          wr_en_r   <= buf_onehot(2'd0);
          wr_col_r  <= col_r;
          wr_data_r <= {PIX_W{1'b0}};
          col_r     <= col_r + 8'd1;
          if (col_r == COL_LAST) begin
            wr_buf_r    <= 2'd1;
            state_r     <= ST_FILL;
            pix_ready_r <= 1'b1;
          end
        end
`endif
        ST_FILL: begin
          if (pix_valid && pix_ready_r) begin
            wr_en_r   <= buf_onehot(wr_buf_r);
            wr_col_r  <= col_r;
            wr_data_r <= pix_in;
            col_r     <= col_r + 8'd1;
            if (col_r == COL_LAST) begin
              wr_buf_r <= next_buf(wr_buf_r);
              rows_r   <= rows_new_s;
              if (rows_new_s >= MIN_ROWS) begin
                // Just-written buffer is the bottom row; the one after it
                // in rotation holds the top row.
                row_ready_r <= 1'b1;
                reg_sel_r   <= top_sel(next_buf(wr_buf_r));
                row_idx_r   <= 8'(rows_new_s - 9'd2);
                state_r     <= ST_WAIT_ACK;
                pix_ready_r <= 1'b0;
              end
            end
          end
        end
        ST_WAIT_ACK: begin
          if (row_ack) begin
            if (rows_r == LAST_ROWS) begin
`ifdef ROWLOAD_ZERO_PAD_EN
              if (bot_done_r) begin
                state_r      <= ST_DONE;
                frame_done_r <= 1'b1;
              end else begin
                state_r <= ST_PAD_BOT;
              end
`else
              state_r      <= ST_DONE;
              frame_done_r <= 1'b1;
`endif
            end else begin
              state_r     <= ST_FILL;
              pix_ready_r <= 1'b1;
            end
          end
        end
`ifdef ROWLOAD_ZERO_PAD_EN
        ST_PAD_BOT: begin
          wr_en_r   <= buf_onehot(wr_buf_r);
          wr_col_r  <= col_r;
          wr_data_r <= {PIX_W{1'b0}};
          col_r     <= col_r + 8'd1;
          if (col_r == COL_LAST) begin
            row_ready_r <= 1'b1;
            reg_sel_r   <= top_sel(next_buf(wr_buf_r));
            row_idx_r   <= 8'(IMG_ROWS - 1);
            bot_done_r  <= 1'b1;
            state_r     <= ST_WAIT_ACK;
          end
        end
`endif
        ST_DONE: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          pix_ready_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          pix_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_col     = wr_col_r;
  assign wr_data    = wr_data_r;
  assign reg_sel    = reg_sel_r;
  assign row_ready  = row_ready_r;
  assign row_idx    = row_idx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_row_buf_loader.sv
// tb_row_buf_loader: scoreboard bench for row_buf_loader with a 4-row image.
// Stimulus pushes expected writes/windows into queues; a monitor pops and
// compares whenever the DUT shows a write strobe or a row_ready pulse.
// Expectations follow ROWLOAD_ZERO_PAD_EN when it is defined.
module tb_row_buf_loader;

  localparam int ROWS = 4;
`ifdef ROWLOAD_ZERO_PAD_EN
  localparam int PADOFF = 1;
`else
  localparam int PADOFF = 0;
`endif

  typedef struct packed {
    logic [2:0]  en;
    logic [7:0]  col;
    logic [11:0] data;
  } wr_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] idx;
  } win_t;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, row_ack;
  logic [11:0] pix_in;
  logic        pix_ready, row_ready, busy, frame_done;
  logic [2:0]  wr_en, reg_sel;
  logic [7:0]  wr_col, row_idx;
  logic [11:0] wr_data;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  done_seen = 0;
  bit  ack_mode = 1'b0;
  bit  in_wait = 1'b0;
  wr_t  exp_wr[$];
  win_t exp_win[$];
  logic [2:0] oh_tab  [3] = '{3'b001, 3'b010, 3'b100};
  logic [2:0] sel_tab [3] = '{3'b100, 3'b001, 3'b010};

  row_buf_loader #(.PIX_W(12), .IMG_COLS(256), .IMG_ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .reg_sel(reg_sel), .row_ready(row_ready), .row_idx(row_idx), .row_ack(row_ack),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix(input int r, input int c);
    return {4'(r), 8'(c)};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk(pix_ready === 1'b0,    {tag, "_pix_ready"},  pix_ready, 0);
    chk(wr_en === 3'b000,      {tag, "_wr_en"},      wr_en, 0);
    chk(wr_col === 8'd0,       {tag, "_wr_col"},     wr_col, 0);
    chk(wr_data === 12'd0,     {tag, "_wr_data"},    wr_data, 0);
    chk(reg_sel === 3'b000,    {tag, "_reg_sel"},    reg_sel, 0);
    chk(row_ready === 1'b0,    {tag, "_row_ready"},  row_ready, 0);
    chk(row_idx === 8'd0,      {tag, "_row_idx"},    row_idx, 0);
    chk(busy === 1'b0,         {tag, "_busy"},       busy, 0);
    chk(frame_done === 1'b0,   {tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic push_zero_row(input logic [2:0] en);
    wr_t w;
    for (int c = 0; c < 256; c++) begin
      w.en = en; w.col = 8'(c); w.data = 12'd0;
      exp_wr.push_back(w);
    end
  endtask

  // Monitor: pops and compares on every write strobe / window pulse.
  task automatic monitor_loop();
    wr_t w;
    win_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (wr_en !== 3'b000) begin
          chk(exp_wr.size() != 0, "unexpected_write", {wr_en, wr_col}, 0);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk(wr_en === w.en,     "wr_en",   wr_en, w.en);
            chk(wr_col === w.col,   "wr_col",  wr_col, w.col);
            chk(wr_data === w.data, "wr_data", wr_data, w.data);
          end
        end
        if (row_ready === 1'b1) begin
          chk(wr_en !== 3'b000 && wr_col === 8'd255, "row_ready_with_last_write", {wr_en, wr_col}, {3'b111, 8'd255});
          chk(exp_win.size() != 0, "unexpected_row_ready", row_idx, 0);
          if (exp_win.size() != 0) begin
            e = exp_win.pop_front();
            chk(reg_sel === e.sel, "reg_sel", reg_sel, e.sel);
            chk(row_idx === e.idx, "row_idx", row_idx, e.idx);
          end
        end
        if (frame_done === 1'b1) done_seen++;
        if (in_wait) begin
          chk(pix_ready === 1'b0, "pix_ready_in_wait", pix_ready, 0);
          chk(wr_en === 3'b000,   "write_in_wait",     wr_en, 0);
        end
      end
    end
  endtask

  // Delayed acknowledge: 50 cycles after each row_ready when ack_mode is set.
  task automatic acker_loop();
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && row_ready === 1'b1 && ack_mode) begin
        @(posedge clk); #1 in_wait = 1'b1;
        repeat (49) @(posedge clk);
        #1 row_ack = 1'b1;
        @(posedge clk); #1 row_ack = 1'b0; in_wait = 1'b0;
      end
    end
  endtask

  // Pixel driver: offers {row,col} pixels, pushes an expected write per accept.
  task automatic drive(input bit gaps, input int stop_row, input int stop_col, output bit aborted);
    int r = 0;
    int c = 0;
    int budget = 0;
    bit acc;
    wr_t w;
    aborted = 1'b0;
    while (r < ROWS) begin
      if (r == stop_row && c == stop_col) begin
        pix_valid = 1'b0;
        aborted = 1'b1;
        return;
      end
      pix_in = pix(r, c);
      pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = pix_valid && (pix_ready === 1'b1);
      if (acc) begin
        w.en = oh_tab[(r + PADOFF) % 3]; w.col = 8'(c); w.data = pix(r, c);
        exp_wr.push_back(w);
`ifdef ROWLOAD_ZERO_PAD_EN
        if (r == ROWS - 1 && c == 255) push_zero_row(oh_tab[(ROWS + 1) % 3]);
`endif
      end
      @(posedge clk); #1;
      if (acc) begin
        if (c == 255) begin c = 0; r++; end
        else c++;
      end
      budget++;
      if (budget > 20000) begin
        n_cmp++; n_fail++;
        $display("FAIL drive_timeout: row %0d col %0d not accepted within 20000 cycles", r, c);
        pix_valid = 1'b0;
        aborted = 1'b1;
        return;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input int stop_row, input int stop_col,
                           input bit poke_start, output bit aborted);
    int done0;
    int waited;
    win_t e;
    done0 = done_seen;
    for (int k = 1 - PADOFF; k <= ROWS - 2 + PADOFF; k++) begin
      e.sel = sel_tab[(k - 1 + PADOFF) % 3];
      e.idx = 8'(k);
      exp_win.push_back(e);
    end
`ifdef ROWLOAD_ZERO_PAD_EN
    push_zero_row(3'b001);
`endif
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk(busy === 1'b1, "busy_after_start", busy, 1);
    if (poke_start) begin
      fork
        begin
          repeat (300) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      join_none
    end
    drive(gaps, stop_row, stop_col, aborted);
    if (aborted) return;
    waited = 0;
    while (done_seen == done0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk(done_seen - done0 == 1, "frame_done_count", done_seen - done0, 1);
    chk(exp_wr.size() == 0,  "writes_outstanding",  exp_wr.size(), 0);
    chk(exp_win.size() == 0, "windows_outstanding", exp_win.size(), 0);
    chk(busy === 1'b0, "busy_after_done", busy, 0);
  endtask

  initial begin
    bit ab;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 12'd0; row_ack = 1'b0;
    fork
      monitor_loop();
      acker_loop();
    join_none
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst = 1'b0;

    // Continuous stream, row_ack held high (also high throughout FILL),
    // plus a stray start pulse mid-frame.
    ack_mode = 1'b0; row_ack = 1'b1;
    run_frame(1'b0, -1, -1, 1'b1, ab);

    // Random valid gaps, acknowledge delayed by 50 cycles.
    row_ack = 1'b0; ack_mode = 1'b1;
    run_frame(1'b1, -1, -1, 1'b0, ab);

    // Reset at column 100 of row 2, then a clean replay.
    ack_mode = 1'b0; row_ack = 1'b1;
    run_frame(1'b0, 2, 100, 1'b0, ab);
    chk(ab == 1'b1, "abort_point_reached", ab, 1);
    @(negedge clk); #2 rst = 1'b1;
    #1 check_reset("midframe");
    exp_wr.delete();
    exp_win.delete();
    @(posedge clk); #3 rst = 1'b0;
    run_frame(1'b0, -1, -1, 1'b0, ab);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
